// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// the responder FSM state type and a helper that maps a size code to a byte count.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Number of bytes touched by an access; zero for the illegal encoding.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-lane storage: four independent byte-wide lanes, each with its own row
// address and write enable, read asynchronously as a 4-byte port.
// Contents are never reset.
module dmem_byte_array #(
  parameter int ROW_W = 11
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [3:0][ROW_W-1:0] row,
  input  logic [3:0][7:0]       wdata,
  output logic [3:0][7:0]       rdata
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [0:(1 << ROW_W) - 1];

    // Per-lane write port.
    always_ff @(posedge clk) begin
      if (we[l]) begin
        mem[row[l]] <= wdata[l];
      end
    end

    assign rdata[l] = mem[row[l]];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with a fixed number of wait states.
// valid/ready: a transfer happens on a rising edge where valid and ready are
// both 1; the request side is only ready in IDLE, and the response stays
// valid and unchanged in RESP until the initiator takes it with rsp_ready.
// Optional build macro: DMEM_ALIGN_CHECK_EN turns misaligned half/word
// accesses into errors; without it they complete byte-wise, wrapping at the
// top of storage.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int ROW_W = ADDR_W - 2;
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  dmem_state_t state, state_next;
  logic [CNT_W-1:0] cnt;

  logic        lat_we, lat_signed;
  logic [31:0] lat_addr, lat_wdata;
  logic [1:0]  lat_size;

  logic        cur_we, cur_signed;
  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  cur_size;

  logic        accept, enter_resp;
  logic        align_err, acc_err;
  logic [2:0]  nbytes;
  logic [ADDR_W-1:0] addr_k [4];

  logic [3:0]            lane_we;
  logic [3:0][ROW_W-1:0] lane_row;
  logic [3:0][7:0]       lane_wdata, lane_rdata;
  logic [31:0]           raw_word, load_data;

  assign accept     = req_valid && (state == IDLE);
  // Commit/read edge; a reset on that edge discards the access.
  assign enter_resp = !rst && (state != RESP) && (state_next == RESP);

  // Live request fields while IDLE (zero-wait path), latched fields otherwise.
  always_comb begin
    cur_we     = lat_we;
    cur_addr   = lat_addr;
    cur_size   = lat_size;
    cur_signed = lat_signed;
    cur_wdata  = lat_wdata;
    if (state == IDLE) begin
      cur_we     = req_we;
      cur_addr   = req_addr;
      cur_size   = req_size;
      cur_signed = req_signed;
      cur_wdata  = req_wdata;
    end
  end

  // Access error: illegal size, address beyond storage, optional misalignment.
  always_comb begin
    align_err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    align_err = ((cur_size == SZ_HALF) && cur_addr[0]) ||
                ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00));
`endif
    acc_err = (cur_size == SZ_ILLEGAL) || (cur_addr[31:ADDR_W] != '0) || align_err;
    nbytes  = size_bytes(cur_size);
  end

  // Byte k of the access lives at addr+k, wrapping modulo the storage size.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      addr_k[k] = cur_addr[ADDR_W-1:0] + ADDR_W'(k);
    end
  end

  // Steer each access byte to the lane selected by its low address bits.
  always_comb begin
    lane_we    = '0;
    lane_row   = '0;
    lane_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      lane_row[addr_k[k][1:0]]   = addr_k[k][ADDR_W-1:2];
      lane_wdata[addr_k[k][1:0]] = cur_wdata[8*k +: 8];
      lane_we[addr_k[k][1:0]]    = enter_resp && cur_we && !acc_err && (3'(k) < nbytes);
    end
  end

  // Gather lane read data back into access byte order.
  always_comb begin
    raw_word = '0;
    for (int k = 0; k < 4; k++) begin
      raw_word[8*k +: 8] = lane_rdata[addr_k[k][1:0]];
    end
  end

  // Size the load result with zero or sign extension.
  always_comb begin
    case (cur_size)
      SZ_BYTE: load_data = {{24{cur_signed & raw_word[7]}},  raw_word[7:0]};
      SZ_HALF: load_data = {{16{cur_signed & raw_word[15]}}, raw_word[15:0]};
      default: load_data = raw_word;
    endcase
  end

  dmem_byte_array #(.ROW_W(ROW_W)) u_array (
    .clk   (clk),
    .we    (lane_we),
    .row   (lane_row),
    .wdata (lane_wdata),
    .rdata (lane_rdata)
  );

  // State register and wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE:    if (accept) cnt <= CNT_W'(WAIT_CYCLES);
        WAIT:    cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Next-state: RESP is entered on the edge where the counter reaches zero.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt <= CNT_W'(1)) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  // Capture request fields on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we     <= req_we;
      lat_addr   <= req_addr;
      lat_size   <= req_size;
      lat_signed <= req_signed;
      lat_wdata  <= req_wdata;
    end
  end

  // Response registers: loaded entering RESP, held, cleared once taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || cur_we) ? '0 : load_data;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, byte-address width of the storage (2^ADDR_W bytes).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, initiator request present.
REQ-006 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_size, input, 2, 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_signed, input, 1, sign-extend load data; ignored for stores.
REQ-011 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-012 SHALL have port rsp_valid, output, 1, response present.
REQ-013 SHALL have port rsp_ready, input, 1, initiator accepts response.
REQ-014 SHALL have port rsp_rdata, output, 32, load result, zero for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1, request failed.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-018 A request SHALL be accepted on a rising edge with req_valid and req_ready both 1; all req_* fields are latched then.
REQ-019 On acceptance the FSM SHALL go to WAIT loading a counter with WAIT_CYCLES, or straight to RESP if WAIT_CYCLES = 0.
REQ-020 WAIT SHALL decrement once per cycle and go to RESP on the edge where the counter reaches 0.
REQ-021 rsp_valid SHALL first be 1 in cycle N+1+WAIT_CYCLES for acceptance edge N.
REQ-022 The store commit and the load read SHALL both happen on the edge entering RESP.
REQ-023 rsp_valid, rsp_rdata and rsp_err SHALL hold stable in RESP until an edge with rsp_ready = 1, which returns the FSM to IDLE.
REQ-024 Storage SHALL be little-endian: byte k of the data maps to address addr+k.
REQ-025 A load SHALL zero-extend, or sign-extend from bit 7 (byte) or bit 15 (half) when req_signed = 1.
REQ-026 A store SHALL write only the lower 1, 2 or 4 bytes of req_wdata per req_size.
REQ-027 rsp_err SHALL be 1 when req_size = 11 or when req_addr[31:ADDR_W] is nonzero.
REQ-028 An error SHALL not modify storage and SHALL return rsp_rdata = 0.
REQ-029 With alignment checking compiled out, multi-byte accesses at the top of storage SHALL wrap modulo 2^ADDR_W.

Reset
REQ-030 rst SHALL force IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
REQ-031 rst asserted in WAIT SHALL discard the pending store uncommitted; storage contents SHALL never be reset.

Configuration
REQ-032 With DMEM_ALIGN_CHECK_EN defined, a half access at an odd address or a word access with addr[1:0] != 0 SHALL set rsp_err and follow REQ-028.
REQ-033 Without DMEM_ALIGN_CHECK_EN, misaligned accesses SHALL complete byte-wise per REQ-024 and REQ-029 with no error.

Structure
REQ-034 Package dmem_pkg SHALL hold the req_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-035 Storage SHALL be the sub-module dmem_byte_array: four byte lanes with a per-lane write enable and a 4-byte read port.

Verification
REQ-036 Word store 0xDEADBEEF at 0x10, then signed byte load at 0x13 -> rsp_rdata = 0xFFFFFFDE, rsp_err = 0.
REQ-037 Half store 0x8001 at 0x20, then unsigned half load at 0x20 -> 0x00008001; signed half load -> 0xFFFF8001.
REQ-038 WAIT_CYCLES = 2, request accepted at edge 5 -> rsp_valid rises in cycle 8; rsp_ready held 0 for 3 cycles -> response stable and req_ready = 0 throughout.
REQ-039 Load at 0x00002000 with ADDR_W = 13 -> rsp_err = 1, rsp_rdata = 0; req_size = 11 store -> rsp_err = 1 and a re-read of the target address shows it unchanged.
REQ-040 Word store at 0x11 -> with DMEM_ALIGN_CHECK_EN, rsp_err = 1 and no write; without it, bytes land at 0x11 to 0x14; a word store at 0x1FFF wraps to 0x0000 to 0x0002.
REQ-041 rst asserted one cycle after store acceptance -> rsp_valid = 0, req_ready = 1 next cycle, and a subsequent load of that address returns the old value.
